// File: rtl/row_bram_writer.sv
// rtl/row_bram_writer.sv - packs nibble pixels into 32-bit words and writes them to row BRAM
module row_bram_writer #(
  parameter int WIDTH     = 640,
  parameter int ROW_COUNT = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic [31:0] bram_data_in,
  output logic [9:0]  bram_x_pos,
  output logic [6:0]  bram_local_y_pos,
  output logic        bram_write,
  output logic        row_done,
  output logic        band_done
);

  localparam int WORDS   = WIDTH / 8;
  localparam int COL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WORDS - 1);
  localparam logic [6:0]       LAST_ROW = 7'(ROW_COUNT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETUP   = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       nib_cnt;
  logic [31:0]      word_buf;
  logic [COL_W-1:0] word_col;
  logic [6:0]       local_row;

  // Collect nibbles, present the finished word for a setup cycle, then strobe the write.
  // Output data/address are only loaded on the edge into SETUP so the BRAM sees
  // them stable for a full cycle ahead of and during the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= COLLECT;
      nib_cnt          <= 3'd0;
      word_buf         <= 32'd0;
      word_col         <= '0;
      local_row        <= 7'd0;
      pix_ready        <= 1'b1;
      bram_data_in     <= 32'd0;
      bram_x_pos       <= 10'd0;
      bram_local_y_pos <= 7'd0;
      bram_write       <= 1'b0;
      row_done         <= 1'b0;
      band_done        <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (pix_valid) begin
            if (pix_sof) begin
              // Start of frame restarts the word at (0,0); any partial word is dropped.
              word_buf  <= {28'd0, pix_data};
              nib_cnt   <= 3'd1;
              word_col  <= '0;
              local_row <= 7'd0;
            end else if (nib_cnt == 3'd7) begin
              bram_data_in     <= {pix_data, word_buf[27:0]};
              bram_x_pos       <= 10'(word_col) << 3;
              bram_local_y_pos <= local_row;
              nib_cnt          <= 3'd0;
              pix_ready        <= 1'b0;
              state            <= SETUP;
            end else begin
              word_buf[{nib_cnt, 2'b00} +: 4] <= pix_data;
              nib_cnt                         <= nib_cnt + 3'd1;
            end
          end
        end
        SETUP: begin
          bram_write <= 1'b1;
          row_done   <= (word_col == LAST_COL);
          band_done  <= (word_col == LAST_COL) && (local_row == LAST_ROW);
          state      <= WRITE;
        end
        WRITE: begin
          bram_write <= 1'b0;
          row_done   <= 1'b0;
          band_done  <= 1'b0;
          pix_ready  <= 1'b1;
          state      <= COLLECT;
          if (word_col == LAST_COL) begin
            word_col  <= '0;
            local_row <= (local_row == LAST_ROW) ? 7'd0 : local_row + 7'd1;
          end else begin
            word_col <= word_col + COL_W'(1);
          end
        end
        default: begin
          state      <= COLLECT;
          pix_ready  <= 1'b1;
          bram_write <= 1'b0;
          row_done   <= 1'b0;
          band_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_bram_writer.sv
// tb/tb_row_bram_writer.sv - directed table-driven bench for row_bram_writer
module tb_row_bram_writer;

  localparam int W = 640;
  localparam int R = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [31:0] bram_data_in;
  logic [9:0]  bram_x_pos;
  logic [6:0]  bram_local_y_pos;
  logic        bram_write;
  logic        row_done;
  logic        band_done;

  row_bram_writer #(.WIDTH(W), .ROW_COUNT(R)) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .bram_data_in(bram_data_in),
    .bram_x_pos(bram_x_pos), .bram_local_y_pos(bram_local_y_pos),
    .bram_write(bram_write), .row_done(row_done), .band_done(band_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [9:0]  x;
    logic [6:0]  y;
    logic        rd;
    logic        bd;
  } wr_t;
  wr_t wq[$];

  logic [31:0] snap_d;
  logic [9:0]  snap_x;
  logic [6:0]  snap_y;

  // write recorder plus SETUP->WRITE stability check
  always @(negedge clk) begin
    if (!reset && !pix_ready && !bram_write) begin
      snap_d = bram_data_in;
      snap_x = bram_x_pos;
      snap_y = bram_local_y_pos;
    end
    if (bram_write) begin
      wq.push_back('{d: bram_data_in, x: bram_x_pos, y: bram_local_y_pos, rd: row_done, bd: band_done});
      chk("stable_data", bram_data_in, snap_d);
      chk("stable_x", 32'(bram_x_pos), 32'(snap_x));
      chk("stable_y", 32'(bram_local_y_pos), 32'(snap_y));
    end
  end

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] d, input logic s);
    int guard = 0;
    pix_data  = d;
    pix_sof   = s;
    pix_valid = 1'b1;
    while (!pix_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  typedef struct {
    logic [31:0] seq;    // arrival order, first nibble in seq[31:28]
    logic [31:0] exp_d;
    logic [9:0]  exp_x;
  } vec_t;
  vec_t tbl[6];

  int cnt;

  initial begin
    tbl[0] = '{32'h12345678, 32'h87654321, 10'd0};
    tbl[1] = '{32'h00000000, 32'h00000000, 10'd8};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 10'd16};
    tbl[3] = '{32'h0123ABCD, 32'hDCBA3210, 10'd24};
    tbl[4] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 10'd32};
    tbl[5] = '{32'h9ABCDEF1, 32'h1FEDCBA9, 10'd40};

    pix_data = 4'd0; pix_valid = 1'b0; pix_sof = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(pix_ready), 32'd1);
    chk("rst_write", 32'(bram_write), 32'd0);
    chk("rst_data", bram_data_in, 32'd0);
    chk("rst_x", 32'(bram_x_pos), 32'd0);
    chk("rst_y", 32'(bram_local_y_pos), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_band_done", 32'(band_done), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // table: one word per record, exact SETUP / WRITE / COLLECT timing
    for (int v = 0; v < 6; v++) begin
      logic [31:0] s;
      s = tbl[v].seq;
      for (int k = 0; k < 8; k++) push(s[31 - 4*k -: 4], 1'b0);
      chk("setup_ready", 32'(pix_ready), 32'd0);
      chk("setup_write", 32'(bram_write), 32'd0);
      chk("setup_data", bram_data_in, tbl[v].exp_d);
      chk("setup_x", 32'(bram_x_pos), 32'(tbl[v].exp_x));
      chk("setup_y", 32'(bram_local_y_pos), 32'd0);
      idle(1);
      chk("write_strobe", 32'(bram_write), 32'd1);
      chk("write_ready", 32'(pix_ready), 32'd0);
      chk("write_data", bram_data_in, tbl[v].exp_d);
      chk("write_x", 32'(bram_x_pos), 32'(tbl[v].exp_x));
      chk("write_row_done", 32'(row_done), 32'd0);
      idle(1);
      chk("after_write", 32'(bram_write), 32'd0);
      chk("after_ready", 32'(pix_ready), 32'd1);
    end

    // full row of 4'hA
    do_reset();
    wq.delete();
    for (int i = 0; i < W; i++) push(4'hA, 1'b0);
    idle(3);
    chk("row_writes", 32'(wq.size()), 32'd80);
    if (wq.size() == 80) begin
      for (int i = 0; i < 80; i++) begin
        chk("row_x", 32'(wq[i].x), 32'(8*i));
        chk("row_d", wq[i].d, 32'hAAAAAAAA);
        chk("row_y", 32'(wq[i].y), 32'd0);
        chk("row_rd", 32'(wq[i].rd), (i == 79) ? 32'd1 : 32'd0);
        chk("row_bd", 32'(wq[i].bd), 32'd0);
      end
    end
    for (int i = 0; i < 8; i++) push(4'hA, 1'b0);
    idle(3);
    chk("row_next_cnt", 32'(wq.size()), 32'd81);
    if (wq.size() == 81) begin
      chk("row_next_x", 32'(wq[80].x), 32'd0);
      chk("row_next_y", 32'(wq[80].y), 32'd1);
    end

    // full band
    do_reset();
    wq.delete();
    for (int i = 0; i < W*R; i++) push(4'h5, 1'b0);
    idle(3);
    chk("band_writes", 32'(wq.size()), 32'(80*R));
    if (wq.size() == 80*R) begin
      chk("band_last_x", 32'(wq[80*R-1].x), 32'd632);
      chk("band_last_y", 32'(wq[80*R-1].y), 32'(R-1));
      chk("band_last_rd", 32'(wq[80*R-1].rd), 32'd1);
      chk("band_last_bd", 32'(wq[80*R-1].bd), 32'd1);
    end
    cnt = 0;
    foreach (wq[i]) if (wq[i].bd) cnt++;
    chk("band_bd_count", 32'(cnt), 32'd1);
    cnt = 0;
    foreach (wq[i]) if (wq[i].rd) cnt++;
    chk("band_rd_count", 32'(cnt), 32'(R));
    for (int i = 0; i < 8; i++) push(4'h5, 1'b0);
    idle(3);
    chk("band_wrap_x", 32'(wq[wq.size()-1].x), 32'd0);
    chk("band_wrap_y", 32'(wq[wq.size()-1].y), 32'd0);
    chk("band_wrap_bd", 32'(wq[wq.size()-1].bd), 32'd0);

    // start of frame discards a partial word
    do_reset();
    wq.delete();
    for (int i = 0; i < 16; i++) push(4'h1, 1'b0);
    for (int i = 0; i < 5; i++) push(4'h5, 1'b0);
    push(4'h3, 1'b1);
    for (int i = 0; i < 7; i++) push(4'h0, 1'b0);
    idle(3);
    chk("sof_writes", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk("sof_prev_x", 32'(wq[1].x), 32'd8);
      chk("sof_d", wq[2].d, 32'h00000003);
      chk("sof_x", 32'(wq[2].x), 32'd0);
      chk("sof_y", 32'(wq[2].y), 32'd0);
    end

    // reset during WRITE of x16 y2
    do_reset();
    wq.delete();
    for (int i = 0; i < 1296; i++) push(4'h2, 1'b0);
    for (int i = 0; i < 8; i++) push(4'h9, 1'b0);
    idle(1);
    chk("abort_pre_write", 32'(bram_write), 32'd1);
    chk("abort_pre_x", 32'(bram_x_pos), 32'd16);
    chk("abort_pre_y", 32'(bram_local_y_pos), 32'd2);
    reset = 1'b1;
    #1;
    chk("abort_write", 32'(bram_write), 32'd0);
    chk("abort_ready", 32'(pix_ready), 32'd1);
    chk("abort_data", bram_data_in, 32'd0);
    chk("abort_x", 32'(bram_x_pos), 32'd0);
    chk("abort_y", 32'(bram_local_y_pos), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    chk("abort_no_write", 32'(wq.size()), 32'd162);
    for (int i = 0; i < 8; i++) push(4'h7, 1'b0);
    idle(3);
    chk("abort_next_cnt", 32'(wq.size()), 32'd163);
    if (wq.size() == 163) begin
      chk("abort_next_d", wq[162].d, 32'h77777777);
      chk("abort_next_x", 32'(wq[162].x), 32'd0);
      chk("abort_next_y", 32'(wq[162].y), 32'd0);
    end

    // random valid gaps over one row
    do_reset();
    wq.delete();
    for (int i = 0; i < W; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      push(4'(i % 16), 1'b0);
    end
    idle(3);
    chk("gap_writes", 32'(wq.size()), 32'd80);
    if (wq.size() == 80) begin
      for (int i = 0; i < 80; i++) begin
        chk("gap_d", wq[i].d, (i % 2 == 0) ? 32'h76543210 : 32'hFEDCBA98);
        chk("gap_x", 32'(wq[i].x), 32'(8*i));
        chk("gap_y", 32'(wq[i].y), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
